// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned ADDR_W     = 5;

  typedef logic [ADDR_W-1:0]     reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : regfile_pkg

// File: rtl/regfile_sb_tracker.sv
// Busy-bit scoreboard: set on accepted issue, cleared on writeback, plus hazard/stall logic.
// REGFILE_WRITE_BYPASS_EN: a register being written this cycle no longer counts as busy.
module regfile_sb_tracker
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  reg_addr_t        ra1,
  input  reg_addr_t        ra2,
  input  logic [NREGS-1:0] clr_vec,
  input  logic             issue_valid,
  input  reg_addr_t        issue_rd,
  input  logic             issue_uses_rd,
  output logic             stall,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] busy_eff;
  logic             src_haz;
  logic             dst_haz;
  logic             accept;

  // Hazard view, issue acceptance and next busy state; an accepted set beats a same-edge clear.
  always_comb begin
`ifdef REGFILE_WRITE_BYPASS_EN
    busy_eff = busy_q & ~clr_vec;
`else
    busy_eff = busy_q;
`endif
    src_haz = ((ra1 != ZERO_REG) && busy_eff[ra1]) ||
              ((ra2 != ZERO_REG) && busy_eff[ra2]);
    dst_haz = issue_uses_rd && busy_eff[issue_rd];
    stall   = issue_valid && (src_haz || dst_haz);
    accept  = issue_valid && !stall && issue_uses_rd && (issue_rd != ZERO_REG);
    busy_d  = busy_q & ~clr_vec;
    if (accept) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule : regfile_sb_tracker

// File: rtl/register_file_sb.sv
// 32x32 register file (r0 hardwired zero) with two combinational reads, one write, and a busy scoreboard.
// REGFILE_WRITE_BYPASS_EN: forward writeback data to same-cycle reads and drop the writeback stall.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_uses_rd,
  output logic              stall,
  output logic [NREGS-1:0]  busy_vec
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  wsel;

  // One-hot write select; bit 0 is never enabled.
  always_comb begin
    wsel = '0;
    for (int i = 1; i < NREGS; i++) begin
      wsel[i] = we && (wa == ADDR_W'(i));
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wsel[i]) begin
        regs_d[i] = wd;
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes; address 0 always reads zero.
  always_comb begin
    rd1 = (ra1 == ZERO_REG) ? '0 : regs_q[ra1];
    rd2 = (ra2 == ZERO_REG) ? '0 : regs_q[ra2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (we && (wa == ra1) && (ra1 != ZERO_REG)) begin
      rd1 = wd;
    end
    if (we && (wa == ra2) && (ra2 != ZERO_REG)) begin
      rd2 = wd;
    end
`endif
  end

  regfile_sb_tracker #(
    .NREGS(NREGS)
  ) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .ra1          (ra1),
    .ra2          (ra2),
    .clr_vec      (wsel),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_uses_rd(issue_uses_rd),
    .stall        (stall),
    .busy_vec     (busy_vec)
  );

endmodule : register_file_sb

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb; expectations follow REGFILE_WRITE_BYPASS_EN if defined.
module tb_register_file_sb;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, wa, issue_rd;
  logic [31:0] rd1, rd2, wd;
  logic        we, issue_valid, issue_uses_rd, stall;
  logic [31:0] busy_vec;

  int vectors = 0;
  int miscompares = 0;

  register_file_sb dut (
    .clk          (clk),
    .rst          (rst),
    .ra1          (ra1),
    .ra2          (ra2),
    .rd1          (rd1),
    .rd2          (rd2),
    .we           (we),
    .wa           (wa),
    .wd           (wd),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_uses_rd(issue_uses_rd),
    .stall        (stall),
    .busy_vec     (busy_vec)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0;
    ra1 = '0; ra2 = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_uses_rd = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    idle();
    issue_valid = 1'b1; issue_rd = 5'd20; issue_uses_rd = 1'b1;
    tick();
    idle();
    ra1 = 5'd17; ra2 = 5'd31;
    #1;
    vectors++;
    if (rd1 !== 32'hA5A5_0011) begin
      miscompares++; $display("FAIL pre_reset_rd1 got %h want %h", rd1, 32'hA5A5_0011);
    end
    vectors++;
    if (rd2 !== 32'hA5A5_001F) begin
      miscompares++; $display("FAIL pre_reset_rd2 got %h want %h", rd2, 32'hA5A5_001F);
    end
    vectors++;
    if (busy_vec !== 32'h0010_0000) begin
      miscompares++; $display("FAIL pre_reset_busy got %h want %h", busy_vec, 32'h0010_0000);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      vectors++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
        miscompares++; $display("FAIL reset_read idx %0d got %h/%h want 0/0", i, rd1, rd2);
      end
    end
    vectors++;
    if (busy_vec !== 32'h0) begin
      miscompares++; $display("FAIL reset_busy got %h want 0", busy_vec);
    end
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall got %b want 0", stall);
    end
    idle();
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 5'd7; wd = 32'hDEAD_BEEF;
    tick();
    idle();
    ra1 = 5'd7;
    #1;
    vectors++;
    if (rd1 !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL wr_rd7 got %h want %h", rd1, 32'hDEAD_BEEF);
    end
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra2 = 5'd0;
    #1;
    vectors++;
    if (rd2 !== 32'h0) begin
      miscompares++; $display("FAIL r0_during_write got %h want 0", rd2);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rd2 !== 32'h0) begin
      miscompares++; $display("FAIL r0_after_write got %h want 0", rd2);
    end
    vectors++;
    if (busy_vec !== 32'h0) begin
      miscompares++; $display("FAIL wb_nonbusy_busy got %h want 0", busy_vec);
    end
  endtask

  task automatic test_raw();
    issue_valid = 1'b1; issue_rd = 5'd5; issue_uses_rd = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++; $display("FAIL raw_first_issue_stall got %b want 0", stall);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (busy_vec !== 32'h0000_0020) begin
      miscompares++; $display("FAIL raw_busy_set got %h want %h", busy_vec, 32'h0000_0020);
    end
    issue_valid = 1'b1; issue_uses_rd = 1'b0; ra1 = 5'd5;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL raw_ra1_stall got %b want 1", stall);
    end
    ra1 = 5'd0; ra2 = 5'd5;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL raw_ra2_stall got %b want 1", stall);
    end
    ra1 = 5'd5; ra2 = 5'd0;
    we = 1'b1; wa = 5'd5; wd = 32'h0000_0055;
    #1;
    vectors++;
    if (stall !== !BYP) begin
      miscompares++; $display("FAIL raw_wb_cycle_stall got %b want %b", stall, !BYP);
    end
    tick();
    we = 1'b0;
    #1;
    vectors++;
    if (busy_vec !== 32'h0) begin
      miscompares++; $display("FAIL raw_busy_cleared got %h want 0", busy_vec);
    end
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++; $display("FAIL raw_after_stall got %b want 0", stall);
    end
    idle();
  endtask

  task automatic test_waw();
    logic [31:0] exp_busy;
    issue_valid = 1'b1; issue_rd = 5'd9; issue_uses_rd = 1'b1;
    tick();
    #1;
    vectors++;
    if (busy_vec !== 32'h0000_0200) begin
      miscompares++; $display("FAIL waw_busy_set got %h want %h", busy_vec, 32'h0000_0200);
    end
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL waw_stall got %b want 1", stall);
    end
    we = 1'b1; wa = 5'd9; wd = 32'h0000_0099;
    #1;
    vectors++;
    if (stall !== !BYP) begin
      miscompares++; $display("FAIL waw_wb_cycle_stall got %b want %b", stall, !BYP);
    end
    tick();
    idle();
    exp_busy = BYP ? 32'h0000_0200 : 32'h0;
    #1;
    vectors++;
    if (busy_vec !== exp_busy) begin
      miscompares++; $display("FAIL waw_set_wins got %h want %h", busy_vec, exp_busy);
    end
    we = 1'b1; wa = 5'd9; wd = 32'h0000_0999;
    tick();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd0; issue_uses_rd = 1'b1;
    tick();
    idle();
    #1;
    vectors++;
    if (busy_vec !== 32'h0) begin
      miscompares++; $display("FAIL waw_r0_never_busy got %h want 0", busy_vec);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rd;
    exp_rd = BYP ? 32'h1234_5678 : 32'h0;
    we = 1'b1; wa = 5'd12; wd = 32'h1234_5678; ra1 = 5'd12; ra2 = 5'd12;
    #1;
    vectors++;
    if (rd1 !== exp_rd || rd2 !== exp_rd) begin
      miscompares++; $display("FAIL byp_same_cycle got %h/%h want %h", rd1, rd2, exp_rd);
    end
    tick();
    we = 1'b0;
    #1;
    vectors++;
    if (rd1 !== 32'h1234_5678 || rd2 !== 32'h1234_5678) begin
      miscompares++; $display("FAIL byp_next_cycle got %h/%h want %h", rd1, rd2, 32'h1234_5678);
    end
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd12;
    #1;
    vectors++;
    if (rd1 !== 32'h0 || rd2 !== 32'h1234_5678) begin
      miscompares++; $display("FAIL byp_r0 got %h/%h want 0/%h", rd1, rd2, 32'h1234_5678);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_rd = 5'd3; issue_uses_rd = 1'b1;
    we = 1'b1; wa = 5'd4; wd = 32'h0000_CAFE;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    ra1 = 5'd4; ra2 = 5'd7;
    #1;
    vectors++;
    if (busy_vec !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_busy got %h want 0", busy_vec);
    end
    vectors++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_regs got %h/%h want 0/0", rd1, rd2);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_raw();
    test_waw();
    test_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_register_file_sb

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- 32 x 32-bit general-purpose register file with two combinational read ports and one synchronous write port.
- Includes a per-register busy scoreboard, set when an instruction issues and cleared on writeback, plus the issue-stall logic.
- Sits between decode (read/issue side) and writeback (write side); write select is a one-hot enable derived from the 5-bit write address.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 32, number of registers; address width is log2(NREGS) = 5.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- rd1  output  DATA_W  read data, port 1 (combinational).
- rd2  output  DATA_W  read data, port 2 (combinational).
- we  input  1  writeback enable.
- wa  input  5  writeback address.
- wd  input  DATA_W  writeback data.
- issue_valid  input  1  decode wants to issue an instruction this cycle.
- issue_rd  input  5  destination register of the issuing instruction.
- issue_uses_rd  input  1  issuing instruction writes a destination.
- stall  output  1  issue refused this cycle (combinational).
- busy_vec  output  NREGS  current scoreboard bits (debug/visibility).

Behaviour:
- Interface timing: one clock, clk; reset rst is synchronous and active-high.
- Reset: all registers = 0; busy_vec = 0. stall = 0 while issue_valid = 0.
- Register 0 is hardwired zero:
  - reads of address 0 return 0;
  - writes to 0 are ignored;
  - busy[0] is never set.
- Write: at a rising edge with we = 1 and wa != 0, reg[wa] <= wd. The one-hot write select is decoded from wa, so exactly one cell is enabled.
- Read: rd1 = reg[ra1], rd2 = reg[ra2]; zero latency, combinational from the current register contents.
- Scoreboard clear: at an edge with we = 1, busy[wa] <= 0.
- Source hazard: src_haz = busy[ra1] or busy[ra2], where a source at address 0 never hazards.
- Destination hazard (WAW): dst_haz = issue_uses_rd and busy[issue_rd].
- A busy bit being cleared by the current writeback still counts as busy for hazard purposes (see Optional Feature).
- stall = issue_valid and (src_haz or dst_haz).
- Issue accept: issue_valid and not stall and issue_uses_rd and issue_rd != 0 → busy[issue_rd] <= 1 at the edge.
- Same edge, same register, clear (writeback) and set (accepted issue): set wins, busy stays 1 for the new producer.
- Writeback to a non-busy register is legal: data is written, busy is unchanged.
- Reset asserted mid-operation: on that edge all registers and busy bits return to 0, and any simultaneous write or issue is discarded.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - If we = 1 and wa == ra1 (ra1 != 0), rd1 = wd in the same cycle; likewise for rd2.
  - A busy bit whose register is being written this cycle counts as not busy for src_haz and dst_haz, removing the one-cycle stall.
- Undefined:
  - Reads return the pre-edge contents.
  - A register being written back still stalls dependents for that cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DATA_W_DEF = 32, NREGS_DEF = 32, ADDR_W = 5, ZERO_REG = 5'd0;
  - typedefs reg_addr_t (logic [4:0]) and reg_data_t (logic [31:0]).
- Sub-module regfile_sb_tracker: the busy-bit array plus set/clear priority and hazard/stall computation.
- Storage and read muxes stay in the top module.

Test Plan:
- Reset:
  - write regs 1..31 with 32'hA5A5_0000 + index, assert rst for one edge;
  - all rdN read 0 and busy_vec == 0.
- Basic write/read:
  - we = 1, wa = 7, wd = 32'hDEAD_BEEF;
  - next cycle ra1 = 7 → rd1 = 32'hDEAD_BEEF;
  - writing wa = 0 with wd = 32'hFFFF_FFFF leaves ra2 = 0 → rd2 = 0.
- Scoreboard RAW:
  - issue with issue_rd = 5 accepted, busy_vec[5] = 1;
  - next issue with ra1 = 5 → stall = 1;
  - we = 1, wa = 5: stall = 1 that cycle without bypass, 0 with REGFILE_WRITE_BYPASS_EN;
  - afterwards busy_vec[5] = 0 and stall = 0.
- WAW and set-wins:
  - busy[9] set; issue_rd = 9 → stall = 1;
  - same cycle as writeback wa = 9 with bypass enabled: issue accepted and busy_vec[9] stays 1.
- Bypass data:
  - with REGFILE_WRITE_BYPASS_EN, we = 1, wa = 12, wd = 32'h1234_5678, ra1 = ra2 = 12 → both read 32'h1234_5678 in the same cycle;
  - without the macro, both return the old value 0.
- Reset mid-issue:
  - rst = 1 on the same edge as an accepted issue to r3 and a write to r4;
  - busy_vec[3] = 0 and reg[4] = 0 afterwards.
